gpi_edge: RTL and testbench

- General-purpose input core for an MMIO slot; the input counterpart of the GPO output core.
- Samples W external input pins through a 2-FF synchronizer and exposes the live value to the processor.
- Detects rising/falling edges into sticky, write-1-to-clear capture bits, with a per-bit interrupt mask and a registered irq.
- Uses the standard slot interface, the same as every other core on the bus.

---
 rtl/gpi_edge.sv | 116 +++++++++++
 tb/tb_gpi_edge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_edge.sv
// General-purpose input slot core: synchronizes W pins, exposes their live value,
// and latches enabled rising/falling edges into sticky W1C capture bits with a masked irq.
module gpi_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] data_in,
    output logic         irq
);

    localparam logic [4:0] REG_DATA    = 5'd0;
    localparam logic [4:0] REG_CAPTURE = 5'd1;
    localparam logic [4:0] REG_RISE_EN = 5'd2;
    localparam logic [4:0] REG_FALL_EN = 5'd3;
    localparam logic [4:0] REG_IRQ_EN  = 5'd4;

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] s3_q, s3_d;
    logic [W-1:0] capture_q, capture_d;
    logic [W-1:0] rise_en_q, rise_en_d;
    logic [W-1:0] fall_en_q, fall_en_d;
    logic [W-1:0] irq_en_q, irq_en_d;
    logic [1:0]   warm_q, warm_d;
    logic         irq_q, irq_d;

    logic [W-1:0] edge_set;
    logic         wr_en;

    // NOTE: every signal gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        s1_d      = data_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        warm_d    = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        capture_d = capture_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        edge_set  = '0;
        wr_en     = cs & write;

        // Until s3 holds a genuinely sampled pin value, s2/s3 differences are reset artefacts.
        if (warm_q == 2'd3) begin
            edge_set = (s2_q & ~s3_q & rise_en_q) | (~s2_q & s3_q & fall_en_q);
        end

        if (wr_en) begin
            case (addr)
                REG_CAPTURE: capture_d = capture_q & ~wr_data[W-1:0];
                REG_RISE_EN: rise_en_d = wr_data[W-1:0];
                REG_FALL_EN: fall_en_d = wr_data[W-1:0];
                REG_IRQ_EN:  irq_en_d  = wr_data[W-1:0];
                default: ;
            endcase
        end

        // A new detection in the same cycle as its W1C keeps the bit set.
        capture_d = capture_d | edge_set;
        irq_d     = |(capture_q & irq_en_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            capture_q <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
            warm_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            capture_q <= capture_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_en_q  <= irq_en_d;
            warm_q    <= warm_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (cs && read) begin
            case (addr)
                REG_DATA:    rd_data[W-1:0] = s2_q;
                REG_CAPTURE: rd_data[W-1:0] = capture_q;
                REG_RISE_EN: rd_data[W-1:0] = rise_en_q;
                REG_FALL_EN: rd_data[W-1:0] = fall_en_q;
                REG_IRQ_EN:  rd_data[W-1:0] = irq_en_q;
                default: ;
            endcase
        end
    end

    assign irq = irq_q;

    if (W < 32) begin : g_wr_hi
        logic unused_wr_hi;
        assign unused_wr_hi = ^wr_data[31:W];
    end

endmodule

// File: tb/tb_gpi_edge.sv
// Self-checking bench for gpi_edge: directed register/edge scenarios followed by
// random traffic, all compared against a pin-history reference model.
module tb_gpi_edge;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs, read, write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] data_in;
    logic         irq;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pin samples taken at each clock edge since reset, plus register images.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_cap, m_rise, m_fall, m_ien;
    logic         m_irq;
    logic [W-1:0] din_cur;

    gpi_edge #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .data_in (data_in),
        .irq     (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_cap  = '0;
        m_rise = '0;
        m_fall = '0;
        m_ien  = '0;
        m_irq  = 1'b0;
    endtask

    // A pin change is seen as an edge two samples later; edges need three samples of history.
    task automatic model_edge(input logic c, input logic w, input logic [4:0] a,
                              input logic [31:0] wd, input logic [W-1:0] din);
        int           e;
        logic [W-1:0] newer, older, set;
        logic         irq_next;
        hist.push_back(din);
        e   = hist.size();
        set = '0;
        if (e >= 4) begin
            newer = hist[e-3];
            older = hist[e-4];
            set   = (newer & ~older & m_rise) | (~newer & older & m_fall);
        end
        irq_next = |(m_cap & m_ien);
        if (c && w) begin
            case (a)
                5'd1: m_cap  = m_cap & ~wd[W-1:0];
                5'd2: m_rise = wd[W-1:0];
                5'd3: m_fall = wd[W-1:0];
                5'd4: m_ien  = wd[W-1:0];
                default: ;
            endcase
        end
        m_cap = m_cap | set;
        m_irq = irq_next;
    endtask

    function automatic logic [31:0] m_read(input logic c, input logic r, input logic [4:0] a);
        logic [31:0] v;
        int          n;
        v = '0;
        n = hist.size();
        if (c && r) begin
            case (a)
                5'd0: v[W-1:0] = (n >= 2) ? hist[n-2] : '0;
                5'd1: v[W-1:0] = m_cap;
                5'd2: v[W-1:0] = m_rise;
                5'd3: v[W-1:0] = m_fall;
                5'd4: v[W-1:0] = m_ien;
                default: ;
            endcase
        end
        return v;
    endfunction

    // Called at a falling edge: drive, check against model, advance one clock.
    task automatic step(input logic c, input logic r, input logic w, input logic [4:0] a,
                        input logic [31:0] wd, input logic [W-1:0] din);
        cs = c; read = r; write = w; addr = a; wr_data = wd; data_in = din; din_cur = din;
        #1;
        chk("rd_data", rd_data, m_read(c, r, a));
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        @(posedge clk);
        model_edge(c, w, a, wd, din);
        @(negedge clk);
    endtask

    task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string tag);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
        #1;
        chk(tag, rd_data, exp);
        cs = 1'b0; read = 1'b0;
    endtask

    initial begin
        logic         rc, rr, rw;
        logic [4:0]   ra;
        logic [31:0]  rwd;
        logic [W-1:0] rdin;

        reset = 1'b1; cs = 0; read = 0; write = 0; addr = '0; wr_data = '0;
        data_in = '1; din_cur = '1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_irq", {31'b0, irq}, 32'd0);
        peek(5'd1, 32'h0, "reset_capture");
        @(negedge clk);
        reset = 1'b0;

        // Warm-up with pins high and rising edges enabled at cycle 1
        step(1, 0, 1, 5'd2, 32'hFF, 8'hFF);
        peek(5'd0, 32'h00, "data_one_edge");
        step(0, 0, 0, 5'd0, 32'h0, 8'hFF);
        peek(5'd0, 32'hFF, "data_two_edges");
        repeat (4) step(1, 1, 0, 5'd1, 32'h0, 8'hFF);
        peek(5'd1, 32'h00, "warmup_capture");
        chk("warmup_irq", {31'b0, irq}, 32'd0);

        // Single rising edge on bit 0, latency and irq
        step(1, 0, 1, 5'd2, 32'h01, 8'h00);
        step(1, 0, 1, 5'd4, 32'h01, 8'h00);
        repeat (3) step(1, 1, 0, 5'd1, 32'h0, 8'h00);
        step(0, 0, 0, 5'd0, 32'h0, 8'h01);
        step(1, 1, 0, 5'd1, 32'h0, 8'h01);
        peek(5'd1, 32'h00, "cap_two_edges");
        step(0, 0, 0, 5'd0, 32'h0, 8'h01);
        peek(5'd1, 32'h01, "cap_three_edges");
        chk("irq_same_edge", {31'b0, irq}, 32'd0);
        step(0, 0, 0, 5'd0, 32'h0, 8'h01);
        chk("irq_next_edge", {31'b0, irq}, 32'd1);
        repeat (4) step(1, 1, 0, 5'd1, 32'h0, 8'h00);
        peek(5'd1, 32'h01, "fall_not_enabled");

        // W1C of individual bits
        step(1, 0, 1, 5'd2, 32'h05, 8'h00);
        step(0, 0, 0, 5'd0, 32'h0, 8'h05);
        repeat (3) step(0, 0, 0, 5'd0, 32'h0, 8'h05);
        peek(5'd1, 32'h05, "cap_05");
        step(1, 0, 1, 5'd1, 32'h04, 8'h05);
        peek(5'd1, 32'h01, "w1c_bit2");
        chk("irq_kept", {31'b0, irq}, 32'd1);
        step(1, 0, 1, 5'd1, 32'h01, 8'h05);
        peek(5'd1, 32'h00, "w1c_bit0");
        chk("irq_lags_clear", {31'b0, irq}, 32'd1);
        step(0, 0, 0, 5'd0, 32'h0, 8'h05);
        chk("irq_cleared", {31'b0, irq}, 32'd0);

        // Falling-edge set collides with W1C of the same bit
        step(1, 0, 1, 5'd3, 32'h80, 8'h05);
        step(0, 0, 0, 5'd0, 32'h0, 8'h85);
        repeat (3) step(0, 0, 0, 5'd0, 32'h0, 8'h85);
        peek(5'd1, 32'h00, "bit7_rise_masked");
        step(0, 0, 0, 5'd0, 32'h0, 8'h05);
        step(0, 0, 0, 5'd0, 32'h0, 8'h05);
        step(1, 0, 1, 5'd1, 32'h80, 8'h05);
        peek(5'd1, 32'h80, "set_beats_w1c");

        // Deselected reads and ignored writes
        cs = 1'b0; read = 1'b1; write = 1'b0; addr = 5'd7;
        #1;
        chk("cs_low_addr7", rd_data, 32'h0);
        addr = 5'd0;
        #1;
        chk("cs_low_addr0", rd_data, 32'h0);
        step(1, 0, 1, 5'd0, 32'hFFFF_FFFF, 8'h05);
        step(1, 0, 1, 5'd9, 32'hFFFF_FFFF, 8'h05);
        peek(5'd2, 32'h05, "rise_en_kept");
        peek(5'd3, 32'h80, "fall_en_kept");
        peek(5'd4, 32'h01, "irq_en_kept");
        peek(5'd1, 32'h80, "capture_kept");
        peek(5'd0, 32'h05, "data_ignores_write");
        step(1, 1, 0, 5'd9, 32'h0, 8'h05);

        // Fill capture, then reset mid-operation
        step(1, 0, 1, 5'd4, 32'hFF, 8'h05);
        step(1, 0, 1, 5'd2, 32'hFF, 8'h05);
        step(1, 0, 1, 5'd3, 32'hFF, 8'h05);
        step(0, 0, 0, 5'd0, 32'h0, 8'hFA);
        repeat (3) step(1, 1, 0, 5'd1, 32'h0, 8'hFA);
        peek(5'd1, 32'hFF, "cap_all");
        chk("irq_before_reset", {31'b0, irq}, 32'd1);
        data_in = 8'hFF;
        reset = 1'b1;
        #1;
        chk("irq_async_drop", {31'b0, irq}, 32'd0);
        peek(5'd1, 32'h0, "rst_capture");
        peek(5'd2, 32'h0, "rst_rise_en");
        peek(5'd3, 32'h0, "rst_fall_en");
        peek(5'd4, 32'h0, "rst_irq_en");
        peek(5'd0, 32'h0, "rst_data");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(1, 0, 1, 5'd2, 32'hFF, 8'hFF);
        step(1, 0, 1, 5'd3, 32'hFF, 8'hFF);
        step(1, 1, 0, 5'd1, 32'h0, 8'hFF);
        peek(5'd1, 32'h0, "suppress_after_reset");
        repeat (3) step(1, 1, 0, 5'd1, 32'h0, 8'hFF);
        peek(5'd1, 32'h0, "no_spurious_edge");

        // Random traffic against the model
        repeat (600) begin
            rdin = din_cur;
            if ($urandom_range(0, 3) == 0) rdin = rdin ^ W'($urandom);
            rc  = ($urandom_range(0, 7) != 0);
            rr  = $urandom_range(0, 1) == 1;
            rw  = ($urandom_range(0, 3) == 0);
            ra  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            rwd = $urandom;
            if (ra == 5'd1) rwd = rwd & $urandom;
            step(rc, rr, rw, ra, rwd, rdin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
